// File: rtl/cpu_pkg.sv
// Shared encodings for the CPU sequencer: control states and branch displacement width.
package cpu_pkg;

  localparam int DISP_W = 8;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_t;

endpackage

// File: rtl/pc_unit.sv
// Program counter: holds the PC and computes jump / relative-branch / sequential next value.
module pc_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 10,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     update,
  input  logic                     jump_en,
  input  logic [ADDR_W-1:0]        jump_target,
  input  logic                     branch_take,
  input  logic signed [DISP_W-1:0] branch_disp,
  output logic [ADDR_W-1:0]        pc
);

  logic [ADDR_W-1:0] pc_next;

  // Size cast of a signed operand sign-extends the displacement to PC width.
  function automatic logic [ADDR_W-1:0] sext_disp(input logic signed [DISP_W-1:0] d);
    logic signed [ADDR_W-1:0] w;
    w = ADDR_W'(d);
    return w;
  endfunction

  always_comb begin
    pc_next = pc + ADDR_W'(1);
    if (jump_en) begin
      pc_next = jump_target;
    end else if (branch_take) begin
      pc_next = pc + ADDR_W'(1) + sext_disp(branch_disp);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (update) begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/control sequencer: owns PC, IR and the single memory port,
// with halt/run/single-step debug control and a retired-instruction counter.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 10,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic                     mem_ready,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic [DATA_W-1:0]        ir,
  output logic                     ir_valid,
  input  logic                     exec_done,
  input  logic                     ls_req,
  input  logic                     ls_we,
  input  logic [ADDR_W-1:0]        ls_addr,
  output logic                     load_valid,
  input  logic                     branch_take,
  input  logic signed [DISP_W-1:0] branch_disp,
  input  logic                     jump_en,
  input  logic [ADDR_W-1:0]        jump_target,
  output logic                     reg_we,
  input  logic                     halt_req,
  input  logic                     run,
  input  logic                     step,
  output logic [ADDR_W-1:0]        pc,
  output logic                     halted,
  output logic [CNT_W-1:0]         retired
);

  state_t state, state_next;
  logic   step_mode, halt_pend, wb;

  logic                     ls_we_q, jump_en_q, branch_take_q;
  logic [ADDR_W-1:0]        ls_addr_q, jump_target_q;
  logic signed [DISP_W-1:0] branch_disp_q;

  pc_unit #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc (
    .clk         (clk),
    .rst         (rst),
    .update      (wb),
    .jump_en     (jump_en_q),
    .jump_target (jump_target_q),
    .branch_take (branch_take_q),
    .branch_disp (branch_disp_q),
    .pc          (pc)
  );

  // halt_pend remembers a halt request seen anywhere in the instruction so a short pulse still halts at WB.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_FETCH;
      step_mode <= 1'b0;
      halt_pend <= 1'b0;
      ir        <= '0;
      retired   <= '0;
    end else begin
      state <= state_next;
      if (state == ST_FETCH && mem_ready) ir <= mem_rdata;
      if (state == ST_WB) begin
        retired   <= retired + CNT_W'(1);
        step_mode <= 1'b0;
        halt_pend <= 1'b0;
      end else if (state == ST_HALT) begin
        if (step) step_mode <= 1'b1;
      end else if (halt_req) begin
        halt_pend <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_EXEC && exec_done) begin
      ls_we_q       <= ls_we;
      ls_addr_q     <= ls_addr;
      jump_en_q     <= jump_en;
      jump_target_q <= jump_target;
      branch_take_q <= branch_take;
      branch_disp_q <= branch_disp;
    end
  end

  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = pc;
    ir_valid   = 1'b0;
    load_valid = 1'b0;
    reg_we     = 1'b0;
    halted     = 1'b0;
    wb         = 1'b0;
    case (state)
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) state_next = ST_DECODE;
      end
      ST_DECODE: begin
        ir_valid   = 1'b1;
        state_next = ST_EXEC;
      end
      ST_EXEC: begin
        if (exec_done) state_next = ls_req ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        mem_req  = 1'b1;
        mem_we   = ls_we_q;
        mem_addr = ls_addr_q;
        if (mem_ready) begin
          load_valid = !ls_we_q;
          state_next = ST_WB;
        end
      end
      ST_WB: begin
        reg_we     = 1'b1;
        wb         = 1'b1;
        state_next = (halt_req || halt_pend || step_mode) ? ST_HALT : ST_FETCH;
      end
      ST_HALT: begin
        halted = 1'b1;
        if (step || (run && !halt_req)) state_next = ST_FETCH;
      end
      default: state_next = ST_FETCH;
    endcase
    // Reset abandons any in-flight access in the same cycle.
    if (rst) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      ir_valid   = 1'b0;
      load_valid = 1'b0;
      reg_we     = 1'b0;
      wb         = 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: memory and datapath responders, retire and load/store monitors.
module tb_cpu_sequencer;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 10;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst, mem_req, mem_we, mem_ready, ir_valid, exec_done, ls_req, ls_we;
  logic              load_valid, branch_take, jump_en, reg_we, halt_req, run, step, halted;
  logic [ADDR_W-1:0] mem_addr, ls_addr, jump_target, pc;
  logic [DATA_W-1:0] mem_rdata, ir;
  logic [7:0]        branch_disp;
  logic [CNT_W-1:0]  retired;

  cpu_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RESET_PC('0), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .ir(ir), .ir_valid(ir_valid),
    .exec_done(exec_done), .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr),
    .load_valid(load_valid), .branch_take(branch_take), .branch_disp(branch_disp),
    .jump_en(jump_en), .jump_target(jump_target), .reg_we(reg_we), .halt_req(halt_req),
    .run(run), .step(step), .pc(pc), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ls;
    logic       we;
    logic [9:0] la;
    logic       bt;
    logic [7:0] bd;
    logic       je;
    logic [9:0] jt;
    int         lat;
  } dp_t;
  typedef struct {
    logic [15:0] ir;
    logic [9:0]  pc;
    logic [15:0] ret;
  } exp_t;
  typedef struct {
    logic       we;
    logic [9:0] addr;
  } ls_t;

  dp_t  dp_q[$];
  exp_t exp_q[$];
  ls_t  ls_q[$];

  int          checks = 0;
  int          errors = 0;
  int          retire_seen = 0;
  int          mem_lat = 1;
  logic        hold_ready = 1'b0;
  logic [15:0] mem [0:1023];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic dp_t mk_dp(input logic ls, input logic we, input logic [9:0] la,
                                input logic bt, input logic [7:0] bd, input logic je,
                                input logic [9:0] jt, input int lat);
    dp_t d;
    d.ls = ls; d.we = we; d.la = la; d.bt = bt; d.bd = bd; d.je = je; d.jt = jt; d.lat = lat;
    return d;
  endfunction

  function automatic dp_t plain();
    return mk_dp(1'b0, 1'b0, 10'h0, 1'b0, 8'h00, 1'b0, 10'h0, 1);
  endfunction

  task automatic instr(input dp_t d, input logic [15:0] eir, input logic [9:0] epc,
                       input logic [15:0] eret);
    exp_t e;
    ls_t  l;
    dp_q.push_back(d);
    e.ir = eir; e.pc = epc; e.ret = eret;
    exp_q.push_back(e);
    if (d.ls) begin
      l.we = d.we; l.addr = d.la;
      ls_q.push_back(l);
    end
  endtask

  task automatic wait_retires(input int n);
    int target;
    target = retire_seen + n;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #2;
      if (retire_seen >= target) return;
    end
    errors++; checks++;
    $display("FAIL retire_timeout: got %0d retirements expected %0d", retire_seen, target);
  endtask

  // Memory model: ready after mem_lat waiting cycles; address 0x100 can be held off.
  initial begin
    int w;
    w = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!mem_req) begin
        mem_ready = 1'b0;
        w = 0;
      end else if (hold_ready && mem_addr == 10'h100) begin
        mem_ready = 1'b0;
      end else if (w >= mem_lat) begin
        mem_ready = 1'b1;
        mem_rdata = mem[mem_addr];
        w = 0;
      end else begin
        mem_ready = 1'b0;
        w++;
      end
    end
  end

  // Datapath model: answers each decoded instruction with the next queued execute result.
  initial begin
    dp_t d;
    exec_done = 1'b0; ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0;
    branch_take = 1'b0; branch_disp = '0; jump_en = 1'b0; jump_target = '0;
    forever begin
      @(negedge clk);
      if (ir_valid) begin
        if (dp_q.size() > 0) d = dp_q.pop_front();
        else d = plain();
        repeat (d.lat) @(negedge clk);
        exec_done = 1'b1; ls_req = d.ls; ls_we = d.we; ls_addr = d.la;
        branch_take = d.bt; branch_disp = d.bd; jump_en = d.je; jump_target = d.jt;
        @(negedge clk);
        exec_done = 1'b0; ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0;
        branch_take = 1'b0; branch_disp = '0; jump_en = 1'b0; jump_target = '0;
      end
    end
  end

  // Retire monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reg_we) begin
        if (exp_q.size() == 0) begin
          errors++; checks++;
          $display("FAIL unexpected_retire: got retire at pc %0h expected none", pc);
          retire_seen++;
        end else begin
          e = exp_q.pop_front();
          chk("ir", 32'(ir), 32'(e.ir));
          @(posedge clk); #1;
          chk("pc", 32'(pc), 32'(e.pc));
          chk("retired", 32'(retired), 32'(e.ret));
          retire_seen++;
        end
      end
    end
  end

  // Load/store monitor
  initial begin
    ls_t l;
    forever begin
      @(negedge clk); #1;
      if (load_valid || (mem_req && mem_we && mem_ready)) begin
        if (ls_q.size() == 0) begin
          errors++; checks++;
          $display("FAIL unexpected_ls: got access at %0h expected none", mem_addr);
        end else begin
          l = ls_q.pop_front();
          chk("ls_addr", 32'(mem_addr), 32'(l.addr));
          chk("ls_we", 32'(mem_we), 32'(l.we));
          chk("load_valid", 32'(load_valid), 32'(!l.we));
          chk("ls_ready", 32'(mem_ready), 32'd1);
          @(posedge clk); #1;
          chk("ls_wb", 32'(reg_we), 32'd1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    rst = 1'b1; halt_req = 1'b0; run = 1'b0; step = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 16'h5A00 + 16'(i);

    repeat (2) @(posedge clk); #1;
    chk("reset_mem_req", 32'(mem_req), 32'd0);
    chk("reset_pc", 32'(pc), 32'd0);
    chk("reset_ir", 32'(ir), 32'd0);
    chk("reset_retired", 32'(retired), 32'd0);
    chk("reset_reg_we", 32'(reg_we), 32'd0);

    instr(plain(), 16'h5A00, 10'd1, 16'd1);
    instr(plain(), 16'h5A01, 10'd2, 16'd2);
    instr(plain(), 16'h5A02, 10'd3, 16'd3);
    @(negedge clk); rst = 1'b0;
    wait_retires(3);

    // Slow fetch at pc 3: request and address must hold while ready stays low.
    mem_lat = 4;
    instr(plain(), 16'h5A03, 10'd4, 16'd4);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      chk("stall_req", 32'(mem_req), 32'd1);
      chk("stall_addr", 32'(mem_addr), 32'd3);
      chk("stall_ir", 32'(ir), 32'h5A02);
    end
    mem_lat = 1;
    wait_retires(1);

    instr(plain(), 16'h5A04, 10'd5, 16'd5);
    instr(mk_dp(1'b0, 1'b0, 10'h0, 1'b1, 8'hFD, 1'b0, 10'h0, 1), 16'h5A05, 10'd3, 16'd6);
    instr(mk_dp(1'b0, 1'b0, 10'h0, 1'b1, 8'h10, 1'b1, 10'd200, 1), 16'h5A03, 10'd200, 16'd7);
    instr(mk_dp(1'b0, 1'b0, 10'h0, 1'b0, 8'h00, 1'b1, 10'd1023, 2), 16'h5AC8, 10'd1023, 16'd8);
    instr(plain(), 16'h5DFF, 10'd0, 16'd9);
    instr(mk_dp(1'b1, 1'b0, 10'h3F0, 1'b0, 8'h00, 1'b0, 10'h0, 1), 16'h5A00, 10'd1, 16'd10);
    instr(mk_dp(1'b1, 1'b1, 10'h012, 1'b0, 8'h00, 1'b0, 10'h0, 1), 16'h5A01, 10'd2, 16'd11);
    wait_retires(7);

    // Short halt pulse during a long execute.
    instr(mk_dp(1'b0, 1'b0, 10'h0, 1'b0, 8'h00, 1'b0, 10'h0, 3), 16'h5A02, 10'd3, 16'd12);
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clk);
      if (ir_valid) found = 1'b1;
    end
    chk("decode_seen", 32'(found), 32'd1);
    @(negedge clk); halt_req = 1'b1;
    @(negedge clk); halt_req = 1'b0;
    wait_retires(1);
    chk("halted_after_halt", 32'(halted), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("halt_idle_req", 32'(mem_req), 32'd0);
      chk("halt_pc", 32'(pc), 32'd3);
    end

    instr(plain(), 16'h5A03, 10'd4, 16'd13);
    @(negedge clk); step = 1'b1;
    @(negedge clk); step = 1'b0;
    wait_retires(1);
    repeat (2) @(negedge clk); #1;
    chk("halted_after_step", 32'(halted), 32'd1);
    chk("step_retired", 32'(retired), 32'd13);

    @(negedge clk); run = 1'b1; halt_req = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk("halt_beats_run", 32'(halted), 32'd1);
    end

    hold_ready = 1'b1;
    instr(plain(), 16'h5A04, 10'd5, 16'd14);
    instr(plain(), 16'h5A05, 10'd6, 16'd15);
    dp_q.push_back(mk_dp(1'b1, 1'b0, 10'h100, 1'b0, 8'h00, 1'b0, 10'h0, 1));
    @(negedge clk); halt_req = 1'b0;
    @(negedge clk); run = 1'b0;
    wait_retires(2);

    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clk); #1;
      if (mem_req && mem_addr == 10'h100) found = 1'b1;
    end
    chk("mem_wait_seen", 32'(found), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("mem_wait_req", 32'(mem_req), 32'd1);
      chk("mem_wait_addr", 32'(mem_addr), 32'h100);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);

    hold_ready = 1'b0;
    halt_req = 1'b1;
    instr(plain(), 16'h5A00, 10'd1, 16'd1);
    @(negedge clk); rst = 1'b0;
    wait_retires(1);
    repeat (2) @(negedge clk); #1;
    chk("halted_after_restart", 32'(halted), 32'd1);
    halt_req = 1'b0;

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("ls_q_drained", 32'(ls_q.size()), 32'd0);
    chk("dp_q_drained", 32'(dp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
